// File: rtl/det_event_logger.sv
// Detection event logger: timestamps each det_in pulse into a FIFO and keeps
// a saturating detection count plus a sticky overflow flag for dropped events.
module det_event_logger #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     det_in,
  input  logic                     rd_ready,
  input  logic                     clr_ovf,
  output logic                     rd_valid,
  output logic [TS_W-1:0]          rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [9:0]               total_count,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] EMPTY_LVL = {LVL_W{1'b0}};
  localparam logic [9:0] CNT_MAX = 10'd1023;

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [9:0]       total_q, total_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  logic [TS_W-1:0]  mem [DEPTH];

  logic full, empty, do_push, do_pop, drop;

  // Next-state logic for timestamp, pointers, occupancy, count and flags.
  always_comb begin
    full     = (level_q == FULL_LVL);
    empty    = (level_q == EMPTY_LVL);
    do_pop   = rd_ready & ~empty;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    do_push  = det_in & (~full | do_pop);
    drop     = det_in & full & ~do_pop;

    ts_d     = ts_q + TS_W'(1);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    total_d  = total_q;
    ovf_d    = ovf_q;

    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // A drop wins over a coincident clear so the loss is never hidden.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    if (det_in && (total_q != CNT_MAX)) begin
      total_d = total_q + 10'd1;
    end else begin
      total_d = total_q;
    end

    valid_d = (level_d != EMPTY_LVL);
  end

  // Control state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q     <= {TS_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      level_q  <= EMPTY_LVL;
      total_q  <= 10'd0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      ts_q     <= ts_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      total_q  <= total_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
    end
  end

  // Timestamp storage; contents are only meaningful below the level count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= ts_q;
    end
  end

  assign rd_valid    = valid_q;
  assign rd_data     = mem[rd_ptr_q];
  assign level       = level_q;
  assign total_count = total_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_det_event_logger.sv
// Self-checking bench for det_event_logger: directed table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_det_event_logger;

  localparam int DEPTH = 8;
  localparam int TS_W  = 10;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   det_in = 1'b0;
  logic                   rd_ready = 1'b0;
  logic                   clr_ovf = 1'b0;
  logic                   rd_valid;
  logic [TS_W-1:0]        rd_data;
  logic [$clog2(DEPTH):0] level;
  logic [9:0]             total_count;
  logic                   overflow;

  det_event_logger #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk(clk), .rst(rst), .det_in(det_in), .rd_ready(rd_ready),
    .clr_ovf(clr_ovf), .rd_valid(rd_valid), .rd_data(rd_data),
    .level(level), .total_count(total_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int q_m[$];
  int ts_m;
  int total_m;
  bit ovf_m;

  typedef struct {
    bit det; bit rdy; bit clr;
    bit v; int d; int l; bit o;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_m.delete();
    ts_m = 0;
    total_m = 0;
    ovf_m = 1'b0;
  endtask

  task automatic model_edge(input bit det, input bit rdy, input bit clr);
    bit full;
    bit pop;
    full = (q_m.size() == DEPTH);
    pop  = (q_m.size() != 0) && rdy;
    if (pop) void'(q_m.pop_front());
    if (det && (!full || pop)) q_m.push_back(ts_m);
    if (det && full && !pop) ovf_m = 1'b1;
    else if (clr) ovf_m = 1'b0;
    if (det && total_m < 1023) total_m++;
    ts_m = (ts_m + 1) % (1 << TS_W);
  endtask

  task automatic chk_model();
    chk("m_valid", int'(rd_valid), int'(q_m.size() != 0));
    chk("m_level", int'(level), q_m.size());
    if (q_m.size() != 0) chk("m_data", int'(rd_data), q_m[0]);
    chk("m_total", int'(total_count), total_m);
    chk("m_ovf", int'(overflow), int'(ovf_m));
  endtask

  // Apply inputs, take one edge, update model, check #1 after the edge.
  task automatic step(input bit det, input bit rdy, input bit clr);
    det_in = det;
    rd_ready = rdy;
    clr_ovf = clr;
    @(posedge clk);
    model_edge(det, rdy, clr);
    #1;
    chk_model();
  endtask

  // Assert reset between edges, check outputs clear at once, release before next edge.
  task automatic hard_reset();
    #2;
    rst = 1'b0;
    #1;
    chk("rst_valid", int'(rd_valid), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_total", int'(total_count), 0);
    chk("rst_ovf", int'(overflow), 0);
    model_reset();
    det_in = 1'b0;
    rd_ready = 1'b0;
    clr_ovf = 1'b0;
    rst = 1'b1;
  endtask

  task automatic add_vec(input bit det, input bit rdy, input bit clr,
                         input bit v, input int d, input int l, input bit o);
    vec_t e;
    e.det = det; e.rdy = rdy; e.clr = clr;
    e.v = v; e.d = d; e.l = l; e.o = o;
    tbl.push_back(e);
  endtask

  initial begin
    // Detections at cycles 3, 7, 12 held, then drained in order.
    repeat (3) add_vec(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    add_vec(1'b1, 1'b0, 1'b0, 1'b1, 3, 1, 1'b0);
    repeat (3) add_vec(1'b0, 1'b0, 1'b0, 1'b1, 3, 1, 1'b0);
    add_vec(1'b1, 1'b0, 1'b0, 1'b1, 3, 2, 1'b0);
    repeat (4) add_vec(1'b0, 1'b0, 1'b0, 1'b1, 3, 2, 1'b0);
    add_vec(1'b1, 1'b0, 1'b0, 1'b1, 3, 3, 1'b0);
    add_vec(1'b0, 1'b1, 1'b0, 1'b1, 7, 2, 1'b0);
    add_vec(1'b0, 1'b1, 1'b0, 1'b1, 12, 1, 1'b0);
    add_vec(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    add_vec(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    hard_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].det, tbl[i].rdy, tbl[i].clr);
      chk("tbl_valid", int'(rd_valid), int'(tbl[i].v));
      chk("tbl_level", int'(level), tbl[i].l);
      chk("tbl_ovf", int'(overflow), int'(tbl[i].o));
      if (tbl[i].v) chk("tbl_data", int'(rd_data), tbl[i].d);
    end

    // Overfill: 10 detections into 8 entries.
    hard_reset();
    repeat (10) step(1'b1, 1'b0, 1'b0);
    chk("fill_level", int'(level), 8);
    chk("fill_ovf", int'(overflow), 1);
    chk("fill_total", int'(total_count), 10);
    chk("fill_head", int'(rd_data), 0);

    // Drop coinciding with clear keeps overflow set; a clean clear drops it.
    step(1'b1, 1'b0, 1'b1);
    chk("drop_clr_ovf", int'(overflow), 1);
    step(1'b0, 1'b0, 1'b1);
    chk("clr_ovf", int'(overflow), 0);

    // Push and pop together while full.
    step(1'b1, 1'b1, 1'b0);
    chk("full_pp_level", int'(level), 8);
    chk("full_pp_ovf", int'(overflow), 0);
    chk("full_pp_head", int'(rd_data), 1);
    repeat (8) step(1'b0, 1'b1, 1'b0);
    chk("drain_valid", int'(rd_valid), 0);

    // Reset mid-operation with level 5 and overflow set.
    hard_reset();
    repeat (10) step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    chk("pre_rst_level", int'(level), 5);
    chk("pre_rst_ovf", int'(overflow), 1);
    hard_reset();
    step(1'b1, 1'b1, 1'b0);
    chk("post_rst_level", int'(level), 1);
    chk("post_rst_data", int'(rd_data), 0);
    step(1'b0, 1'b0, 1'b0);
    chk("post_rst_hold", int'(level), 1);
    step(1'b0, 1'b1, 1'b0);

    // Long run with continuous draining: count saturation and timestamp wrap.
    hard_reset();
    for (int i = 0; i < 1035; i++) step(1'b1, 1'b1, 1'b0);
    chk("sat_total", int'(total_count), 1023);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    chk("sat_hold", int'(total_count), 1023);

    // Randomized traffic, with one reset in the middle.
    hard_reset();
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) hard_reset();
      step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 10);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
